uart_cmd_ctrl: RTL

- Sequences the UART receive byte stream (rx_data/po_flag from the UART receiver) into SDRAM access commands.
- Parses a fixed frame: header, command, address, optional write data.
- Issues one write or read request to the SDRAM controller through a req/ack handshake.
- Sits between the UART receiver and the SDRAM controller's command port; holds off parsing while a request is outstanding.

---
 rtl/uart_cmd_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_ctrl.sv
// UART byte-stream frame parser that issues one SDRAM write/read request per frame.
// Optional trailing XOR checksum byte: define UART_CMD_CHKSUM_EN.
module uart_cmd_ctrl #(
  parameter logic [7:0] HEADER      = 8'h55,
  parameter int         ADDR_BYTES  = 3,
  parameter int         DATA_BYTES  = 2,
  parameter int         TIMEOUT_CYC = 50_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_data,
  input  logic                    po_flag,
  output logic                    wr_req,
  output logic                    rd_req,
  output logic [8*ADDR_BYTES-1:0] cmd_addr,
  output logic [8*DATA_BYTES-1:0] wr_data,
  input  logic                    wr_ack,
  input  logic                    rd_ack,
  output logic                    busy,
  output logic                    err_flag
);

  localparam int MAXB = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int BCW  = (MAXB > 1) ? $clog2(MAXB) : 1;
  localparam int TW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [BCW-1:0] ADDR_LAST = BCW'(ADDR_BYTES - 1);
  localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_BYTES - 1);
  localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    ISSUE_WR,
`ifdef UART_CMD_CHKSUM_EN
    ISSUE_RD,
    CHK
`else
    ISSUE_RD
`endif
  } state_t;

  state_t         state_reg;
  logic [BCW-1:0] byte_cnt_reg;
  logic [TW-1:0]  tmo_cnt_reg;
  logic           is_wr_reg;
  logic           timed;
`ifdef UART_CMD_CHKSUM_EN
  logic [7:0]     chk_reg;
`endif

  // Inter-byte timeout only runs while a frame is being received.
  always_comb begin
    timed = (state_reg == CMD) || (state_reg == ADDR) || (state_reg == DATA);
`ifdef UART_CMD_CHKSUM_EN
    timed = timed || (state_reg == CHK);
`endif
  end

  assign busy = (state_reg != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      byte_cnt_reg <= '0;
      tmo_cnt_reg  <= '0;
      is_wr_reg    <= 1'b0;
      wr_req       <= 1'b0;
      rd_req       <= 1'b0;
      cmd_addr     <= '0;
      wr_data      <= '0;
      err_flag     <= 1'b0;
`ifdef UART_CMD_CHKSUM_EN
      chk_reg      <= '0;
`endif
    end else begin
      err_flag <= 1'b0;
      if (timed && !po_flag && tmo_cnt_reg == TMO_LAST) begin
        err_flag     <= 1'b1;
        state_reg    <= IDLE;
        byte_cnt_reg <= '0;
        tmo_cnt_reg  <= '0;
      end else begin
        // A po_flag on the terminal count lands here, so the byte wins.
        tmo_cnt_reg <= (timed && !po_flag) ? tmo_cnt_reg + 1'b1 : '0;
        case (state_reg)
          IDLE: if (po_flag && rx_data == HEADER) state_reg <= CMD;
          CMD: if (po_flag) begin
            if (rx_data == 8'h01 || rx_data == 8'h02) begin
              is_wr_reg    <= (rx_data == 8'h01);
              byte_cnt_reg <= '0;
              state_reg    <= ADDR;
`ifdef UART_CMD_CHKSUM_EN
              chk_reg      <= rx_data;
`endif
            end else begin
              err_flag  <= 1'b1;
              state_reg <= IDLE;
            end
          end
          ADDR: if (po_flag) begin
            cmd_addr <= {cmd_addr[8*ADDR_BYTES-9:0], rx_data};
`ifdef UART_CMD_CHKSUM_EN
            chk_reg  <= chk_reg ^ rx_data;
`endif
            if (byte_cnt_reg == ADDR_LAST) begin
              byte_cnt_reg <= '0;
              if (is_wr_reg) begin
                state_reg <= DATA;
              end else begin
`ifdef UART_CMD_CHKSUM_EN
                state_reg <= CHK;
`else
                state_reg <= ISSUE_RD;
                rd_req    <= 1'b1;
`endif
              end
            end else begin
              byte_cnt_reg <= byte_cnt_reg + 1'b1;
            end
          end
          DATA: if (po_flag) begin
            wr_data <= {wr_data[8*DATA_BYTES-9:0], rx_data};
`ifdef UART_CMD_CHKSUM_EN
            chk_reg <= chk_reg ^ rx_data;
`endif
            if (byte_cnt_reg == DATA_LAST) begin
              byte_cnt_reg <= '0;
`ifdef UART_CMD_CHKSUM_EN
              state_reg    <= CHK;
`else
              state_reg    <= ISSUE_WR;
              wr_req       <= 1'b1;
`endif
            end else begin
              byte_cnt_reg <= byte_cnt_reg + 1'b1;
            end
          end
`ifdef UART_CMD_CHKSUM_EN
          CHK: if (po_flag) begin
            if (rx_data != chk_reg) begin
              err_flag  <= 1'b1;
              state_reg <= IDLE;
            end else if (is_wr_reg) begin
              state_reg <= ISSUE_WR;
              wr_req    <= 1'b1;
            end else begin
              state_reg <= ISSUE_RD;
              rd_req    <= 1'b1;
            end
          end
`endif
          // Bytes arriving while a request is outstanding are dropped as overruns.
          ISSUE_WR: begin
            if (po_flag) err_flag <= 1'b1;
            if (wr_ack) begin
              wr_req    <= 1'b0;
              state_reg <= IDLE;
            end
          end
          ISSUE_RD: begin
            if (po_flag) err_flag <= 1'b1;
            if (rd_ack) begin
              rd_req    <= 1'b0;
              state_reg <= IDLE;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule
